// File: rtl/mod_n_counter_rtl.sv
// mod_n_counter_rtl: free-running modulo-n up counter (0..n-1, then wraps to 0).
// Defining MOD_N_COUNTER_TC_EN adds a registered terminal-count output tc.
module mod_n_counter_rtl #(
    parameter int n = 4,
    parameter int size = 3
) (
    input  logic            clk,
    input  logic            rst,
`ifdef MOD_N_COUNTER_TC_EN
    output logic            tc,
`endif
    output logic [size-1:0] out
);
    localparam logic [size-1:0] last = size'(n - 1);

    if (n < 2 || n > 2 ** size) begin : g_bad_n
        $error("mod_n_counter_rtl: n=%0d is outside 2..2**size (size=%0d)", n, size);
    end

    logic [size-1:0] nxt;

    // The >= compare also pulls any out-of-range value back to 0.
    always_comb nxt = (out >= last) ? '0 : out + size'(1);

    always_ff @(posedge clk)
        if (!rst) out <= '0;
        else out <= nxt;

`ifdef MOD_N_COUNTER_TC_EN
    always_ff @(posedge clk)
        if (!rst) tc <= 1'b0;
        else tc <= (nxt == last);
`endif
endmodule

// File: tb/tb_mod_n_counter_rtl.sv
// tb_mod_n_counter_rtl: checks n=4, n=8 and n=5 counters against an edge-count model.
module tb_mod_n_counter_rtl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [2:0] out4, out8, out5;
`ifdef MOD_N_COUNTER_TC_EN
    logic tc4, tc8, tc5;
`endif
    int errs = 0;
    int checks = 0;
    longint k = 0;

    always #5 clk = ~clk;

    mod_n_counter_rtl #(.n(4), .size(3)) dut4 (
        .clk(clk), .rst(rst),
`ifdef MOD_N_COUNTER_TC_EN
        .tc(tc4),
`endif
        .out(out4)
    );
    mod_n_counter_rtl #(.n(8), .size(3)) dut8 (
        .clk(clk), .rst(rst),
`ifdef MOD_N_COUNTER_TC_EN
        .tc(tc8),
`endif
        .out(out8)
    );
    mod_n_counter_rtl #(.n(5), .size(3)) dut5 (
        .clk(clk), .rst(rst),
`ifdef MOD_N_COUNTER_TC_EN
        .tc(tc5),
`endif
        .out(out5)
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // Model: k counts counting edges since the last sampled reset; value is k mod n.
    task automatic step(input logic r);
        rst = r;
        @(posedge clk);
        if (!r) k = 0;
        else k++;
        #1;
        chk("out_n4", {29'd0, out4}, 32'(k % 4));
        chk("out_n8", {29'd0, out8}, 32'(k % 8));
        chk("out_n5", {29'd0, out5}, 32'(k % 5));
`ifdef MOD_N_COUNTER_TC_EN
        chk("tc_n4", {31'd0, tc4}, {31'd0, k % 4 == 3});
        chk("tc_n8", {31'd0, tc8}, {31'd0, k % 8 == 7});
        chk("tc_n5", {31'd0, tc5}, {31'd0, k % 5 == 4});
`endif
    endtask

    initial begin
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < 8; i++) step(1'b1);
        for (int i = 0; i < 8 && k % 4 != 2; i++) step(1'b1);
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < 4; i++) step(1'b1);
        // Reset pulse that never spans a rising edge must be ignored.
        rst = 1'b0;
        #3;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1);
        for (int i = 0; i < 16; i++) step(1'b1);
        for (int i = 0; i < 200; i++) step($urandom_range(0, 15) != 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
